// File: rtl/div_share_scheduler_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared constants for the divider-sharing scheduler: op-field
//               bit positions and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    // Op field decoding: bit0 selects unsigned, bit1 selects remainder.
    localparam int DIV_OP_UNSIGNED_BIT = 0;
    localparam int DIV_OP_REM_BIT      = 1;

    // Scheduler state encoding.
    localparam int         STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/div_share_scheduler_if.sv
// ============================================================================
// Module      : div_share_scheduler_if
// Description : Bundles the requester, divider and writeback signals of the
//               divider-sharing scheduler.
//               master : scheduler side (drives grants, divider start/operands,
//                        writeback result, busy)
//               slave  : environment side (requesters, div32, CDB, control)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_share_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic                    hci_rdy;
    logic                    flush;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*XLEN-1:0]    req_a;
    logic [NREQ*XLEN-1:0]    req_b;
    logic [NREQ*3-1:0]       req_op;
    logic [NREQ*TAG_W-1:0]   req_vregid;
    logic                    div_in_en;
    logic [XLEN-1:0]         div_a;
    logic [XLEN-1:0]         div_b;
    logic                    div_signed;
    logic                    div_idle;
    logic                    div_out_en;
    logic [XLEN-1:0]         div_q;
    logic [XLEN-1:0]         div_rem;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [TAG_W-1:0]        wb_vregid;
    logic [XLEN-1:0]         wb_val;
    logic                    busy;

    modport master (
        input  hci_rdy, flush, req_valid, req_a, req_b, req_op, req_vregid,
               div_idle, div_out_en, div_q, div_rem, wb_ready,
        output req_ready, div_in_en, div_a, div_b, div_signed,
               wb_valid, wb_vregid, wb_val, busy
    );

    modport slave (
        output hci_rdy, flush, req_valid, req_a, req_b, req_op, req_vregid,
               div_idle, div_out_en, div_q, div_rem, wb_ready,
        input  req_ready, div_in_en, div_a, div_b, div_signed,
               wb_valid, wb_vregid, wb_val, busy
    );

endinterface

`default_nettype wire

// File: rtl/div_share_scheduler_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Round-robin picker. Selects the first asserted request at or
//               after the pointer, wrapping around.
// Ports       : req_i   - request vector
//               ptr_i   - highest-priority position
//               grant_o - one-hot winner
//               idx_o   - winner index
//               any_o   - at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int w_pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[PTR_W'(w_pos)]) begin
                any_o                  = 1'b1;
                grant_o[PTR_W'(w_pos)] = 1'b1;
                idx_o                  = PTR_W'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_share_scheduler.sv
// ============================================================================
// Module      : div_share_scheduler
// Description : Shares one multi-cycle divider among NREQ requesters.
//               Round-robin grant, one-cycle divider start pulse, result
//               capture on the divider strobe, valid/ready writeback.
// Ports       : clk      - clock
//               rst      - synchronous reset, active low
//               sched_if - requester / divider / writeback bundle (master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_share_scheduler
    import div_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    div_share_scheduler_if.master sched_if
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [XLEN-1:0]    a_q, b_q;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               div_in_en_q;
    logic               wb_valid_q;
    logic [XLEN-1:0]    wb_val_q;
    logic [TAG_W-1:0]   wb_vregid_q;
    logic               squash_q;

    logic [NREQ-1:0]    w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;
    logic               w_issue_ok;
    logic               w_issue;
    logic               w_wb_hs;

    rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
        .req_i   (sched_if.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    // Grants only from IDLE with the divider free and the pipeline running;
    // rst is included so no handshake is offered while reset is held.
    assign w_issue_ok = (state_q == ST_IDLE) && rst && sched_if.hci_rdy &&
                        sched_if.div_idle && !sched_if.flush;
    assign w_issue    = w_issue_ok && w_any;
    assign w_wb_hs    = wb_valid_q && sched_if.wb_ready && sched_if.hci_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_issue) state_d = ST_BUSY;
            // A flush arriving with the strobe discards the result too.
            ST_BUSY: if (sched_if.div_out_en)
                         state_d = (squash_q || sched_if.flush) ? ST_IDLE : ST_DONE;
            ST_DONE: if (sched_if.flush || w_wb_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            div_in_en_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_val_q    <= '0;
            wb_vregid_q <= '0;
            squash_q    <= 1'b0;
        end else begin
            div_in_en_q <= w_issue;
            if (w_issue) begin
                a_q      <= sched_if.req_a[int'(w_idx)*XLEN +: XLEN];
                b_q      <= sched_if.req_b[int'(w_idx)*XLEN +: XLEN];
                op_q     <= sched_if.req_op[int'(w_idx)*3 +: 2];
                tag_q    <= sched_if.req_vregid[int'(w_idx)*TAG_W +: TAG_W];
                rr_ptr_q <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
            end
            // The divider cannot be aborted, so a flush while it runs only
            // marks the op; the result is dropped when it arrives.
            if (state_q == ST_BUSY) begin
                if (sched_if.div_out_en) begin
                    wb_val_q    <= op_q[DIV_OP_REM_BIT] ? sched_if.div_rem
                                                        : sched_if.div_q;
                    wb_vregid_q <= tag_q;
                    wb_valid_q  <= !(squash_q || sched_if.flush);
                    squash_q    <= 1'b0;
                end else if (sched_if.flush) begin
                    squash_q    <= 1'b1;
                end
            end
            if ((state_q == ST_DONE) && (sched_if.flush || w_wb_hs)) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        sched_if.req_ready  = w_issue_ok ? w_grant : '0;
        sched_if.div_in_en  = div_in_en_q;
        sched_if.div_a      = a_q;
        sched_if.div_b      = b_q;
        sched_if.div_signed = !op_q[DIV_OP_UNSIGNED_BIT];
        sched_if.wb_valid   = wb_valid_q;
        sched_if.wb_val     = wb_val_q;
        sched_if.wb_vregid  = wb_vregid_q;
        sched_if.busy       = (state_q != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_div_share_scheduler.sv
// ============================================================================
// Module      : tb_div_share_scheduler
// Description : Self-checking bench for div_share_scheduler with a div32
//               behavioural model, randomised requesters and a result
//               scoreboard drained by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_share_scheduler;

    localparam int NREQ  = 4;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_share_scheduler_if #(.NREQ(NREQ), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_share_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Requester state
    bit               rv  [NREQ];
    logic [XLEN-1:0]  ra  [NREQ];
    logic [XLEN-1:0]  rb  [NREQ];
    logic [2:0]       rop [NREQ];
    logic [TAG_W-1:0] rtag[NREQ];

    // Reference model of the scheduler at transaction level
    int   mptr;
    bit   outst, have_res, killed, exp_in_en;
    logic [XLEN-1:0] ex_a, ex_b;
    logic ex_signed;

    // div32 model
    bit   drun;
    int   dcnt;
    logic [XLEN-1:0] da, db;
    bit   dsgn;

    // Knobs
    int   p_refill = 0;     // percent chance an empty requester refills
    int   p_flush  = 0;     // per-mille flush probability
    int   p_hci_lo = 0;     // percent of cycles with hci_rdy low
    int   p_wbr    = 100;   // percent of cycles with wb_ready high
    int   lat_min  = 3, lat_max = 6;
    bit   force_wbr0, hci0_while_busy, flush_busy_req, flush_outen_req;

    task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_div(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                                logic [2:0] op);
        logic [XLEN-1:0] q, r;
        if (op[0]) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return op[1] ? r : q;
    endfunction

    task automatic load(int i, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [2:0] op);
        logic [31:0] t;
        t = $urandom;
        rv[i] = 1'b1; ra[i] = a; rb[i] = b; rop[i] = op; rtag[i] = t[TAG_W-1:0];
    endtask

    task automatic rand_op(int i);
        logic [XLEN-1:0] a, b;
        logic [31:0] o;
        a = $urandom;
        b = ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(1, 20)) : XLEN'($urandom);
        if (b == 0) b = 1;
        o = $urandom;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
        load(i, a, b, o[2:0]);
    endtask

    task automatic model_reset();
        mptr = 0; outst = 0; have_res = 0; killed = 0; exp_in_en = 0;
        drun = 0; dcnt = 0;
        sbq.delete();
    endtask

    // One clock cycle: drive at the falling edge, check and update the model
    // 2 time units later (inputs then stay stable until the next rising edge).
    task automatic step();
        bit o;
        int w;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        bus.div_out_en = 1'b0;
        if (drun) begin
            if (dcnt == 0) begin
                bus.div_out_en = 1'b1;
                if (dsgn) begin
                    bus.div_q   = $signed(da) / $signed(db);
                    bus.div_rem = $signed(da) % $signed(db);
                end else begin
                    bus.div_q   = da / db;
                    bus.div_rem = da % db;
                end
                drun = 0;
            end else begin
                dcnt--;
            end
        end
        bus.div_idle = !drun;
        for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] && ($urandom_range(0, 99) < p_refill)) rand_op(i);
            bus.req_valid[i]                = rv[i];
            bus.req_a[i*XLEN +: XLEN]       = ra[i];
            bus.req_b[i*XLEN +: XLEN]       = rb[i];
            bus.req_op[i*3 +: 3]            = rop[i];
            bus.req_vregid[i*TAG_W +: TAG_W] = rtag[i];
        end
        bus.hci_rdy = ($urandom_range(0, 99) >= p_hci_lo);
        if (hci0_while_busy && outst) bus.hci_rdy = 1'b0;
        bus.flush = ($urandom_range(0, 999) < p_flush);
        if (flush_busy_req && outst && !have_res && drun && !bus.div_out_en) begin
            bus.flush = 1'b1; flush_busy_req = 0;
        end
        if (flush_outen_req && bus.div_out_en) begin
            bus.flush = 1'b1; flush_outen_req = 0;
        end
        bus.wb_ready = ($urandom_range(0, 99) < p_wbr) && !force_wbr0 && !bus.flush;
        #2;
        if (!rst) begin
            chk("req_ready_in_reset", XLEN'(bus.req_ready), '0);
            return;
        end
        chk("busy", XLEN'(bus.busy), XLEN'(outst));
        chk("wb_valid", XLEN'(bus.wb_valid), XLEN'(have_res));
        chk("div_in_en", XLEN'(bus.div_in_en), XLEN'(exp_in_en));
        if (exp_in_en) begin
            chk("div_a", bus.div_a, ex_a);
            chk("div_b", bus.div_b, ex_b);
            chk("div_signed", XLEN'(bus.div_signed), XLEN'(ex_signed));
        end
        exp_in_en = 0;
        if (bus.div_in_en) begin
            drun = 1; dcnt = $urandom_range(lat_min, lat_max);
            da = bus.div_a; db = bus.div_b; dsgn = bus.div_signed;
        end
        o  = outst;
        eg = '0;
        w  = -1;
        if (!o) begin
            if (bus.hci_rdy && bus.div_idle && !bus.flush) begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (mptr + k) % NREQ;
                    if (w < 0 && rv[j]) w = j;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
            chk("req_ready", XLEN'(bus.req_ready), XLEN'(eg));
            if (w >= 0) begin
                sbq.push_back('{tag: rtag[w], val: ref_div(ra[w], rb[w], rop[w])});
                ex_a = ra[w]; ex_b = rb[w]; ex_signed = !rop[w][0];
                exp_in_en = 1; outst = 1; killed = 0;
                mptr = (w + 1) % NREQ;
                rv[w] = 0;
            end
        end else if (!have_res) begin
            chk("req_ready_busy", XLEN'(bus.req_ready), '0);
            if (bus.div_out_en) begin
                if (killed || bus.flush) begin
                    void'(sbq.pop_back());
                    outst = 0; killed = 0;
                end else begin
                    have_res = 1;
                end
            end else if (bus.flush) begin
                killed = 1;
            end
        end else begin
            chk("req_ready_done", XLEN'(bus.req_ready), '0);
            if (bus.flush) begin
                void'(sbq.pop_back());
                outst = 0; have_res = 0;
            end else if (bus.wb_ready && bus.hci_rdy) begin
                outst = 0; have_res = 0;
            end
        end
    endtask

    // Monitor: compares every presented writeback against the scoreboard head
    // and retires it on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && !bus.flush && bus.wb_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected actual=tag %h val %h expected=none",
                             bus.wb_vregid, bus.wb_val);
                end else begin
                    e = sbq[0];
                    chk("wb_vregid", XLEN'(bus.wb_vregid), XLEN'(e.tag));
                    chk("wb_val", bus.wb_val, e.val);
                    if (bus.wb_ready && bus.hci_rdy) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic wait_idle(string nm, int max);
        int n;
        n = 0;
        while ((outst || sbq.size() != 0 || rv[0] || rv[1] || rv[2] || rv[3]) && n < max) begin
            step();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL timeout_%s actual=%0d cycles expected=<%0d", nm, n, max);
        end
    endtask

    task automatic wait_cond_res(int max);
        int n;
        n = 0;
        while (!have_res && n < max) begin step(); n++; end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 0; ra[i] = '0; rb[i] = 1; rop[i] = '0; rtag[i] = '0;
        end
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        bus.req_vregid = '0; bus.div_idle = 1'b1; bus.div_out_en = 1'b0;
        bus.div_q = '0; bus.div_rem = '0; bus.wb_ready = 1'b0;
        bus.hci_rdy = 1'b1; bus.flush = 1'b0;
        force_wbr0 = 0; hci0_while_busy = 0; flush_busy_req = 0; flush_outen_req = 0;
        model_reset();

        rst = 1'b0;
        repeat (3) step();
        @(negedge clk); rst = 1'b1;
        step();

        // Directed single-requester ops
        load(0, 32'd100, 32'd7, 3'd0);              wait_idle("q100_7", 60);
        load(0, 32'd100, 32'd7, 3'd2);              wait_idle("r100_7", 60);
        load(0, 32'hFFFF_FFF9, 32'd2, 3'd0);        wait_idle("sq_m7_2", 60);
        load(0, 32'hFFFF_FFF9, 32'd2, 3'd3);        wait_idle("ur_fff9_2", 60);

        // All requesters held valid: round-robin rotation with wrap
        p_refill = 100;
        repeat (60) step();
        p_refill = 0;
        wait_idle("rr", 100);

        // Writeback stall for 10 cycles in DONE
        load(2, 32'd12345, 32'd11, 3'd1);
        load(3, 32'd999, 32'd10, 3'd3);
        wait_cond_res(40);
        force_wbr0 = 1; repeat (10) step(); force_wbr0 = 0;
        wait_idle("wb_stall", 80);

        // Flush while BUSY, then flush coinciding with the result strobe
        load(1, 32'd500, 32'd3, 3'd0);
        load(2, 32'd77, 32'd5, 3'd2);
        flush_busy_req = 1;
        wait_idle("flush_busy", 80);
        load(3, 32'd640, 32'd8, 3'd1);
        load(0, 32'd81, 32'd9, 3'd0);
        flush_outen_req = 1;
        wait_idle("flush_outen", 80);

        // hci_rdy low across the result strobe
        load(1, 32'hFFFF_FF00, 32'd16, 3'd0);
        hci0_while_busy = 1;
        wait_cond_res(40);
        repeat (4) step();
        hci0_while_busy = 0;
        wait_idle("hci_stall", 60);

        // Reset asserted mid-BUSY
        load(2, 32'd1000, 32'd13, 3'd0);
        begin
            int n;
            n = 0;
            while (!(outst && !have_res && drun) && n < 20) begin step(); n++; end
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) rv[i] = 0;
        step(); step();
        @(negedge clk); rst = 1'b1;
        #2;
        chk("wb_valid_after_rst", XLEN'(bus.wb_valid), '0);
        chk("busy_after_rst", XLEN'(bus.busy), '0);
        load(1, 32'd42, 32'd6, 3'd0);
        wait_idle("post_rst", 60);

        // Randomised traffic
        p_refill = 30; p_flush = 20; p_hci_lo = 20; p_wbr = 70;
        lat_min = 1; lat_max = 8;
        repeat (3000) step();
        p_refill = 0; p_flush = 0; p_hci_lo = 0; p_wbr = 100;
        wait_idle("drain", 400);
        chk("scoreboard_empty", XLEN'(sbq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
